// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the input-side IO path. The DMA and the scheduler
// include the same rd_data field offsets, so they live here in one place.
//   - default switch/key widths
//   - rd_data field offsets (for the default widths) and helpers that derive
//     them for other widths (fields are packed LSB-first in the same order)
//   - read FSM state encoding
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int SW_WIDTH_DEF  = 18;
  localparam int KEY_WIDTH_DEF = 4;
  localparam int RD_DATA_WIDTH = 32;

  // Field offset helpers: switches, key levels, pending bits, overflow bit.
  function automatic int key_lsb(input int sw_width);
    return sw_width;
  endfunction

  function automatic int pend_lsb(input int sw_width, input int key_width);
    return sw_width + key_width;
  endfunction

  function automatic int ovf_bit(input int sw_width, input int key_width);
    return sw_width + 2 * key_width;
  endfunction

  // rd_data layout for the default widths.
  localparam int RD_SW_LSB   = 0;
  localparam int RD_KEY_LSB  = key_lsb(SW_WIDTH_DEF);                  // 18
  localparam int RD_PEND_LSB = pend_lsb(SW_WIDTH_DEF, KEY_WIDTH_DEF);  // 22
  localparam int RD_OVF_BIT  = ovf_bit(SW_WIDTH_DEF, KEY_WIDTH_DEF);   // 26

  // Read FSM state encoding.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACK  = 2'd1,
    RD_HOLD = 2'd2
  } rd_state_e;

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Debounces one already-synchronized, active-low key.
//
// A new level is accepted only after the synchronized input has disagreed
// with the accepted level for DEBOUNCE_CYCLES consecutive cycles; any cycle
// of agreement restarts the count, so shorter glitches are ignored.
//
// Ports
//   physical_clock  in   system clock, rising edge
//   n_reset         in   asynchronous active-low reset
//   raw_sync        in   synchronized raw key (0 = pressed)
//   level           out  debounced key state (1 = pressed)
//   press_strobe    out  1-cycle pulse in the cycle whose closing edge moves
//                        level from released to pressed
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic physical_clock,
  input  logic n_reset,
  input  logic raw_sync,
  output logic level,
  output logic press_strobe
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Accepted level kept in the raw (active-low) sense so it compares directly
  // with raw_sync; reset value 1 means released.
  logic                 accepted_raw;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 mismatch;
  logic                 settle;

  always_comb begin
    mismatch = (raw_sync != accepted_raw);
    settle   = mismatch && (cnt == CNT_LAST);
  end

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      accepted_raw <= 1'b1;
      cnt          <= '0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (settle) begin
      accepted_raw <= raw_sync;
      cnt          <= '0;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // The strobe is combinational so the pending bit is set on the same edge
  // that raises level; irq then follows level by exactly one cycle.
  always_comb begin
    level        = ~accepted_raw;
    press_strobe = settle & ~raw_sync;
  end

endmodule

// File: rtl/io_input_port.sv
// -----------------------------------------------------------------------------
// io_input_port
// Samples the board switches and keys, debounces the keys, latches key-press
// events in sticky pending bits and serves everything to the DMA as one
// 32-bit status word over a req/ack read handshake.
//
// Ports
//   physical_clock  in   system clock, all state on rising edge
//   n_reset         in   asynchronous active-low reset
//   IO_input        in   raw switches (active-high, low bits) + keys
//                        (active-low, high bits), asynchronous
//   rd_req          in   DMA read request (level)
//   rd_ack          out  1-cycle pulse, rd_data valid, pending bits cleared
//   rd_data         out  status word, held stable until the next ack
//   key_level       out  debounced key state, 1 = pressed
//   irq             out  registered OR of pending press bits
//   fsm_state       out  read FSM state (debug visibility)
//
// Handshake: the DMA raises rd_req and holds it until it sees rd_ack. The
// request is sampled in IDLE; on that edge rd_data captures the status word
// and pending is cleared, and rd_ack is high for exactly the following cycle.
// The FSM then waits in HOLD until rd_req drops, so a held request never
// produces a second ack.
// -----------------------------------------------------------------------------
module io_input_port
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = SW_WIDTH_DEF,
  parameter int KEY_WIDTH       = KEY_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic                          physical_clock,
  input  logic                          n_reset,
  input  logic [SW_WIDTH+KEY_WIDTH-1:0] IO_input,
  input  logic                          rd_req,
  output logic                          rd_ack,
  output logic [RD_DATA_WIDTH-1:0]      rd_data,
  output logic [KEY_WIDTH-1:0]          key_level,
  output logic                          irq,
  output logic [1:0]                    fsm_state
);

  localparam int IN_WIDTH  = SW_WIDTH + KEY_WIDTH;
  localparam int KEY_LSB   = key_lsb(SW_WIDTH);
  localparam int PEND_LSB  = pend_lsb(SW_WIDTH, KEY_WIDTH);
  localparam int OVF_BIT   = ovf_bit(SW_WIDTH, KEY_WIDTH);

  // Switches reset low, keys reset high (released).
  localparam logic [IN_WIDTH-1:0] SYNC_RST = {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer on every input bit
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= IO_input;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Key debouncers
  // ---------------------------------------------------------------------------
  logic [KEY_WIDTH-1:0] press;

  for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_debouncer (
      .physical_clock (physical_clock),
      .n_reset        (n_reset),
      .raw_sync       (sync2[SW_WIDTH+k]),
      .level          (key_level[k]),
      .press_strobe   (press[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e state;
  rd_state_e state_next;
  logic      take_snap;

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= RD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE: if (rd_req)  state_next = RD_ACK;
      RD_ACK:               state_next = RD_HOLD;
      RD_HOLD: if (!rd_req) state_next = RD_IDLE;
      default:              state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_ack    = (state == RD_ACK);
    take_snap = (state == RD_IDLE) && rd_req;
    fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Status word, pending/overflow and irq
  // ---------------------------------------------------------------------------
  logic [KEY_WIDTH-1:0]     pending;
  logic                     overflow;
  logic                     new_overflow;
  logic [RD_DATA_WIDTH-1:0] status_word;

  always_comb begin
    status_word                          = '0;
    status_word[SW_WIDTH-1:0]            = sync2[SW_WIDTH-1:0];
    status_word[KEY_LSB +: KEY_WIDTH]    = key_level;
    status_word[PEND_LSB +: KEY_WIDTH]   = pending;
    status_word[OVF_BIT]                 = overflow;
    // A press on a key that is still pending means one press went unseen.
    new_overflow                         = |(press & pending);
  end

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (take_snap) begin
      // Every bit in the snapshot is cleared; a press arriving on this same
      // edge is set again so it is reported by the next read.
      pending  <= (pending & ~status_word[PEND_LSB +: KEY_WIDTH]) | press;
      overflow <= new_overflow;
    end else begin
      pending  <= pending | press;
      overflow <= overflow | new_overflow;
    end
  end

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      rd_data <= '0;
    end else if (take_snap) begin
      rd_data <= status_word;
    end
  end

  always_ff @(posedge physical_clock or negedge n_reset) begin
    if (!n_reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |pending;
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
module tb_io_input_port;
  import io_pkg::*;

  localparam int SW = 18;
  localparam int KW = 4;
  localparam int DB = 4;
  localparam int IW = SW + KW;
  localparam logic [IW-1:0] RST_WORD = {{KW{1'b1}}, {SW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk     = 1'b0;
  logic          n_reset = 1'b0;
  logic          rd_req  = 1'b0;
  logic [IW-1:0] io_in   = '1;
  logic          rd_ack;
  logic [31:0]   rd_data;
  logic [KW-1:0] key_level;
  logic          irq;
  logic [1:0]    fsm_state;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  io_input_port #(
    .SW_WIDTH        (SW),
    .KEY_WIDTH       (KW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (2)
  ) dut (
    .physical_clock (clk),
    .n_reset        (n_reset),
    .IO_input       (io_in),
    .rd_req         (rd_req),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .key_level      (key_level),
    .irq            (irq),
    .fsm_state      (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model: inputs reach the logic two samples late; a key flips
  // once DB consecutive delayed samples disagree with the accepted level;
  // a read takes a snapshot, then waits for the request to drop.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] in_d1   = RST_WORD;
  logic [IW-1:0] in_d2   = RST_WORD;
  logic [KW-1:0] m_level = '0;
  int            m_run [KW];
  logic [KW-1:0] m_pend  = '0;
  logic          m_ovf   = 1'b0;
  logic          m_irq   = 1'b0;
  logic          m_ack   = 1'b0;
  logic [31:0]   m_data  = '0;
  int            m_phase = 0;  // 0 waiting for request, 1 acking, 2 waiting for release

  always @(posedge clk or negedge n_reset) begin : ref_model
    logic [KW-1:0] ev;
    logic [KW-1:0] pend_old;
    logic [31:0]   snap;
    logic          pressed;
    if (!n_reset) begin
      in_d1   = RST_WORD;
      in_d2   = RST_WORD;
      m_level = '0;
      for (int k = 0; k < KW; k++) m_run[k] = 0;
      m_pend  = '0;
      m_ovf   = 1'b0;
      m_irq   = 1'b0;
      m_ack   = 1'b0;
      m_data  = '0;
      m_phase = 0;
    end else begin
      snap               = '0;
      snap[SW-1:0]       = in_d2[SW-1:0];
      snap[SW +: KW]     = m_level;
      snap[SW+KW +: KW]  = m_pend;
      snap[SW+2*KW]      = m_ovf;
      pend_old = m_pend;
      m_irq    = |pend_old;
      ev       = '0;
      for (int k = 0; k < KW; k++) begin
        pressed = ~in_d2[SW+k];
        if (pressed != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_level[k] = pressed;
            m_run[k]   = 0;
            ev[k]      = pressed;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      if (m_phase == 0 && rd_req) begin
        m_data  = snap;
        m_pend  = ev;
        m_ovf   = |(ev & pend_old);
        m_phase = 1;
      end else begin
        m_pend = pend_old | ev;
        m_ovf  = m_ovf | (|(ev & pend_old));
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && !rd_req) m_phase = 0;
      end
      m_ack = (m_phase == 1);
      in_d2 = in_d1;
      in_d1 = io_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one read transaction, called just after a falling edge.
  // Returns the captured word and the number of cycles until rd_ack.
  // ---------------------------------------------------------------------------
  task automatic do_read(output logic [31:0] data, output int lat);
    rd_req = 1'b1;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_ack && lat < 20);
    data   = rd_data;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    int          lat;
    n_reset = 1'b0;
    io_in   = '1;
    rd_req  = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", rd_ack); end
    n_vec++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    n_vec++;
    if (key_level !== 4'h0) begin n_fail++; $display("FAIL reset_keys: got %b expected 0000", key_level); end
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_vec++;
    if (fsm_state !== RD_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, RD_IDLE); end
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    do_read(d, lat);
    n_vec++;
    if (lat != 1) begin n_fail++; $display("FAIL reset_read_latency: got %0d expected 1", lat); end
    n_vec++;
    if (d[17:0] !== 18'h3FFFF) begin n_fail++; $display("FAIL reset_read_sw: got %h expected 3ffff", d[17:0]); end
    n_vec++;
    if (d[31:18] !== 14'h0) begin n_fail++; $display("FAIL reset_read_upper: got %h expected 0", d[31:18]); end
  endtask

  task automatic test_glitch();
    io_in[SW+0] = 1'b0;
    repeat (3) @(negedge clk);
    io_in[SW+0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (key_level !== 4'h0 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_cycle%0d: got key_level=%b irq=%b expected 0000/0", i, key_level, irq);
      end
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    int          lat;
    io_in[SW+2] = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (key_level[2] !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b expected 0", key_level[2]); end
    @(negedge clk);
    n_vec++;
    if (key_level[2] !== 1'b1) begin n_fail++; $display("FAIL press_level: got %b expected 1", key_level[2]); end
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_early: got %b expected 0", irq); end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b expected 1", irq); end
    do_read(d, lat);
    n_vec++;
    if (lat != 1) begin n_fail++; $display("FAIL press_read_latency: got %0d expected 1", lat); end
    n_vec++;
    if (d[25:22] !== 4'b0100) begin n_fail++; $display("FAIL press_pending: got %b expected 0100", d[25:22]); end
    n_vec++;
    if (d[21:18] !== 4'b0100) begin n_fail++; $display("FAIL press_key_field: got %b expected 0100", d[21:18]); end
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_cleared: got %b expected 0", irq); end
    io_in[SW+2] = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (irq !== 1'b0 || key_level !== 4'h0) begin
      n_fail++;
      $display("FAIL release_no_event: got irq=%b key_level=%b expected 0/0000", irq, key_level);
    end
  endtask

  task automatic test_double_press();
    logic [31:0] d;
    int          lat;
    for (int rep = 0; rep < 2; rep++) begin
      io_in[SW+1] = 1'b0;
      repeat (8) @(negedge clk);
      io_in[SW+1] = 1'b1;
      repeat (8) @(negedge clk);
    end
    do_read(d, lat);
    n_vec++;
    if (d[25:22] !== 4'b0010) begin n_fail++; $display("FAIL double_pending: got %b expected 0010", d[25:22]); end
    n_vec++;
    if (d[26] !== 1'b1) begin n_fail++; $display("FAIL double_overflow: got %b expected 1", d[26]); end
    do_read(d, lat);
    n_vec++;
    if (d[25:22] !== 4'b0000) begin n_fail++; $display("FAIL double_reread_pending: got %b expected 0000", d[25:22]); end
    n_vec++;
    if (d[26] !== 1'b0) begin n_fail++; $display("FAIL double_reread_overflow: got %b expected 0", d[26]); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    int          lat;
    // Key press settles on the 6th edge; the request is sampled on that edge.
    io_in[SW+3] = 1'b0;
    repeat (5) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL collide_ack: got %b expected 1", rd_ack); end
    n_vec++;
    if (rd_data[25] !== 1'b0) begin n_fail++; $display("FAIL collide_snapshot: got %b expected 0", rd_data[25]); end
    n_vec++;
    if (rd_data[26] !== 1'b0) begin n_fail++; $display("FAIL collide_overflow: got %b expected 0", rd_data[26]); end
    rd_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_irq: got %b expected 1", irq); end
    @(negedge clk);
    do_read(d, lat);
    n_vec++;
    if (d[25:22] !== 4'b1000) begin n_fail++; $display("FAIL collide_kept: got %b expected 1000", d[25:22]); end
    io_in[SW+3] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_handshake();
    int acks;
    int first;
    acks  = 0;
    first = -1;
    rd_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rd_ack) begin
        acks++;
        if (first < 0) first = i;
      end
    end
    n_vec++;
    if (acks != 1) begin n_fail++; $display("FAIL hs_single_ack: got %0d expected 1", acks); end
    n_vec++;
    if (first != 1) begin n_fail++; $display("FAIL hs_ack_latency: got %0d expected 1", first); end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL hs_second_ack: got %b expected 1", rd_ack); end
    @(negedge clk);
    n_vec++;
    if (rd_ack !== 1'b0 || fsm_state !== RD_HOLD) begin
      n_fail++;
      $display("FAIL hs_hold: got ack=%b state=%0d expected 0/%0d", rd_ack, fsm_state, RD_HOLD);
    end
    n_reset = 1'b0;
    #1;
    n_vec++;
    if (rd_ack !== 1'b0 || fsm_state !== RD_IDLE) begin
      n_fail++;
      $display("FAIL hs_reset_hold: got ack=%b state=%0d expected 0/%0d", rd_ack, fsm_state, RD_IDLE);
    end
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack_after_reset: got %b expected 1", rd_ack); end
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int key_left [KW];
    int cool;
    cool = 0;
    for (int k = 0; k < KW; k++) key_left[k] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (key_level !== m_level) begin n_fail++; $display("FAIL rnd_key_level@%0d: got %b expected %b", cyc, key_level, m_level); end
      n_vec++;
      if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq@%0d: got %b expected %b", cyc, irq, m_irq); end
      n_vec++;
      if (rd_ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b expected %b", cyc, rd_ack, m_ack); end
      n_vec++;
      if (rd_data !== m_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, rd_data, m_data); end
      // New stimulus for the next edge.
      for (int k = 0; k < KW; k++) begin
        if (key_left[k] == 0) begin
          io_in[SW+k] = 1'($urandom_range(0, 1));
          key_left[k] = $urandom_range(1, 7);
        end else begin
          key_left[k]--;
        end
      end
      if ($urandom_range(0, 9) == 0) io_in[SW-1:0] = SW'($urandom);
      if (rd_req && rd_ack) begin
        rd_req = 1'b0;
        cool   = 2;
      end else if (cool > 0) begin
        cool--;
      end else if (!rd_req && $urandom_range(0, 5) == 0) begin
        rd_req = 1'b1;
      end
    end
    rd_req = 1'b0;
    io_in[IW-1:SW] = '1;
    repeat (12) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    io_in = '1;
    repeat (2) @(negedge clk);
    test_reset();
    io_in[SW-1:0] = SW'($urandom);
    repeat (3) @(negedge clk);
    test_glitch();
    test_press();
    test_double_press();
    test_collision();
    test_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
